// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one RAM port; define MEM_ARB_ROUND_ROBIN_EN for round-robin ties, else data wins
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_adress,
  output logic [DW-1:0] data_out_ram,
  output logic          ram_enable_write,
  input  logic [DW-1:0] data_in_ram
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic own_d, own_we, arb, pick_d;
  assign arb = !rst && state != BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req && !(if_req && last_d);
  // remember who was served last; reset as "data" so fetch wins the first tie
  always_ff @(posedge clk)
    last_d <= rst ? 1'b1 : (if_gnt || d_gnt) ? d_gnt : last_d;
`else
  assign pick_d = d_req;
`endif
  assign d_gnt = arb && pick_d;
  assign if_gnt = arb && if_req && !pick_d;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state and response strobes; RESP arbitrates like IDLE for back-to-back accesses
  always_comb begin
    state_nx = state;
    if_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (state == BUSY) state_nx = cnt == '0 ? RESP : BUSY;
    else state_nx = (if_gnt || d_gnt) ? BUSY : IDLE;
    if (state == RESP) begin
      if_rvalid = !own_d;
      d_rvalid = own_d;
    end
  end
  // access capture on grant, latency countdown and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      own_d <= 1'b0;
      own_we <= 1'b0;
      ram_enable_write <= 1'b0;
      ram_adress <= '0;
      data_out_ram <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      ram_enable_write <= d_gnt && d_we;
      if (if_gnt || d_gnt) begin
        own_d <= d_gnt;
        own_we <= d_gnt && d_we;
        cnt <= 4'(RAM_LAT - 1);
        ram_adress <= d_gnt ? d_addr : if_addr;
        if (d_gnt && d_we) data_out_ram <= d_wdata;
      end else if (state == BUSY) begin
        cnt <= cnt == '0 ? cnt : cnt - 4'd1;
        if (cnt == '0 && !own_we) begin
          if (own_d) d_rdata <= data_in_ram;
          else if_rdata <= data_in_ram;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench, lane 0 runs RAM_LAT=1 and lane 1 runs RAM_LAT=3
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst [2], if_req [2], if_gnt [2], if_rvalid [2], d_req [2], d_we [2], d_gnt [2], d_rvalid [2], we_o [2];
  logic [31:0] if_addr [2], if_rdata [2], d_addr [2], d_wdata [2], d_rdata [2], ram_a [2], ram_wd [2], ram_rd [2];
  int passed = 0, total = 0;
  typedef struct {bit d; bit we; logic [31:0] addr; logic [31:0] data; int due;} exp_t;
  function automatic logic [31:0] ramf(logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask
  genvar g;
  for (g = 0; g < 2; g++) begin : lane
    localparam int LAT = g == 0 ? 1 : 3;
    exp_t q [$];
    exp_t e;
    int busy = 0, we_at = -1;
    logic [31:0] cur_a = '0, st_d = '0, last_d = '0;
    assign ram_rd[g] = ramf(ram_a[g]);
    mem_arbiter #(.RAM_LAT(LAT)) u (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .ram_adress(ram_a[g]), .data_out_ram(ram_wd[g]), .ram_enable_write(we_o[g]), .data_in_ram(ram_rd[g])
    );
    always @(negedge clk) begin
      if (rst[g]) begin
        q.delete();
        busy = 0;
        we_at = -1;
        last_d = '0;
      end else begin
        chk("we_strobe", 32'(we_o[g]), 32'(cyc == we_at));
        if (cyc == we_at) begin
          chk("st_addr", ram_a[g], cur_a);
          chk("st_data", ram_wd[g], st_d);
        end
        if (busy > 0) begin
          chk("gnt_in_busy", 32'(if_gnt[g] | d_gnt[g]), 32'd0);
          chk("busy_addr", ram_a[g], cur_a);
          busy--;
        end else if (if_gnt[g] | d_gnt[g]) begin
          chk("gnt_onehot", 32'(if_gnt[g] & d_gnt[g]), 32'd0);
          cur_a = d_gnt[g] ? d_addr[g] : if_addr[g];
          st_d = d_wdata[g];
          we_at = d_gnt[g] && d_we[g] ? cyc + 1 : -1;
          busy = LAT;
          q.push_back('{d_gnt[g], d_gnt[g] && d_we[g], cur_a, ramf(cur_a), cyc + LAT + 1});
        end
        if (if_rvalid[g] | d_rvalid[g]) begin
          if (q.size() == 0) chk("spurious_rvalid", 32'(if_rvalid[g] | d_rvalid[g]), 32'd0);
          else begin
            e = q.pop_front();
            chk("rv_cycle", 32'(cyc), 32'(e.due));
            chk("rv_owner", 32'(d_rvalid[g]), 32'(e.d));
            chk("rv_onehot", 32'(if_rvalid[g] & d_rvalid[g]), 32'd0);
            if (!e.d) chk("if_rdata", if_rdata[g], e.data);
            else if (e.we) chk("st_rdata_kept", d_rdata[g], last_d);
            else begin
              chk("d_rdata", d_rdata[g], e.data);
              last_d = e.data;
            end
          end
        end else if (q.size() > 0 && cyc > q[0].due) begin
          chk("rv_missing", 32'(if_rvalid[g] | d_rvalid[g]), 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end
  task automatic wait_gnt(int k, output bit was_d, output int at);
    was_d = 1'b0;
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_gnt[k] || d_gnt[k]) begin
        was_d = d_gnt[k];
        at = cyc;
        return;
      end
    end
    chk("gnt_timeout", 32'(if_gnt[k] | d_gnt[k]), 32'd1);
  endtask
  task automatic acc(int k, bit d, bit we, logic [31:0] a, logic [31:0] wd, output int at);
    bit w;
    if (d) begin
      d_req[k] = 1'b1;
      d_we[k] = we;
      d_addr[k] = a;
      d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1;
      if_addr[k] = a;
    end
    wait_gnt(k, w, at);
    chk("gnt_who", 32'(w), 32'(d));
    @(posedge clk); #1;
    if_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask
  initial begin
    int t, p;
    bit w;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      if_req[k] = 1'b0;
      d_req[k] = 1'b0;
      d_we[k] = 1'b0;
      if_addr[k] = '0;
      d_addr[k] = '0;
      d_wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ram_a", ram_a[k], 32'd0);
      chk("rst_ram_wd", ram_wd[k], 32'd0);
      chk("rst_we", 32'(we_o[k]), 32'd0);
      chk("rst_rvalid", 32'(if_rvalid[k] | d_rvalid[k]), 32'd0);
      chk("rst_rdata", if_rdata[k] | d_rdata[k], 32'd0);
      chk("rst_gnt", 32'(if_gnt[k] | d_gnt[k]), 32'd0);
    end
    @(posedge clk); #1;
    p = cyc;
    acc(0, 1'b0, 1'b0, 32'h10, '0, t);
    chk("fetch_gnt_cycle", 32'(t), 32'(p));
    repeat (3) @(posedge clk);
    #1;
    chk("fetch_rdata_hold", if_rdata[0], 32'hDEADBEEF);
    acc(0, 1'b1, 1'b0, 32'h80, '0, t);
    acc(0, 1'b1, 1'b1, 32'h40, 32'h12345678, t);
    repeat (4) @(posedge clk);
    #1;
    chk("store_keeps_rdata", d_rdata[0], ramf(32'h80));
    chk("wdata_hold", ram_wd[0], 32'h12345678);
    if_req[0] = 1'b1;
    if_addr[0] = 32'h100;
    d_req[0] = 1'b1;
    d_we[0] = 1'b0;
    d_addr[0] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(0, w, t);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("tie_who", 32'(w), 32'(i % 2));
`else
      chk("tie_who", 32'(w), 32'd1);
`endif
      if (i > 0) chk("tie_gap", 32'(t - p), 32'd2);
      p = t;
      @(posedge clk); #1;
      if (w) d_addr[0] += 4;
      else if_addr[0] += 4;
    end
    if_req[0] = 1'b0;
    d_req[0] = 1'b0;
    d_req[1] = 1'b1;
    d_we[1] = 1'b0;
    d_addr[1] = 32'h300;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(1, w, t);
      chk("b2b_who", 32'(w), 32'd1);
      if (i > 0) chk("b2b_gap", 32'(t - p), 32'd4);
      p = t;
      @(posedge clk); #1;
      d_addr[1] += 4;
    end
    d_req[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    d_req[1] = 1'b1;
    d_addr[1] = 32'h400;
    wait_gnt(1, w, t);
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    if_req[1] = 1'b1;
    if_addr[1] = 32'h500;
    @(posedge clk); #1;
    chk("abort_we", 32'(we_o[1]), 32'd0);
    chk("abort_ram_a", ram_a[1], 32'd0);
    chk("abort_rdata", d_rdata[1] | if_rdata[1], 32'd0);
    chk("abort_rvalid", 32'(if_rvalid[1] | d_rvalid[1]), 32'd0);
    chk("abort_gnt", 32'(if_gnt[1] | d_gnt[1]), 32'd0);
    rst[1] = 1'b0;
    p = cyc;
    wait_gnt(1, w, t);
    chk("post_rst_gnt_cycle", 32'(t), 32'(p));
    chk("post_rst_who", 32'(w), 32'd0);
    @(posedge clk); #1;
    if_req[1] = 1'b0;
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter placed between the RISC-V core's two memory requesters, instruction fetch and data load/store, and the one shared RAM port. It serialises accesses with a grant/valid handshake, waits a fixed RAM latency and returns read data to the requester that was granted. Priority on simultaneous requests is fixed (data first) or round-robin, chosen at compile time.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `RAM_LAT`, 1: RAM read latency in cycles. Legal range 1..15.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `if_req` input 1: fetch request.
- `if_addr` input AW: fetch address.
- `if_gnt` output 1: fetch request accepted this cycle.
- `if_rvalid` output 1: fetch data valid (1-cycle pulse).
- `if_rdata` output DW: fetch data.
- `d_req` input 1: data request.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input AW: data address.
- `d_wdata` input DW: store data.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: load data valid, or store acknowledge (1-cycle pulse).
- `d_rdata` output DW: load data.
- `ram_adress` output AW: RAM address.
- `data_out_ram` output DW: RAM write data.
- `ram_enable_write` output 1: RAM write strobe.
- `data_in_ram` input DW: RAM read data.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If no request is pending, the FSM stays in IDLE.
  - Otherwise the arbiter selects one requester and asserts its `*_gnt` combinationally in this cycle.
  - On the clock edge it registers `ram_adress`, `data_out_ram` (store only) and the owner, loads the counter with `RAM_LAT - 1` and moves to BUSY.
- BUSY:
  - `ram_enable_write` is 1 only in the first BUSY cycle, and only when the owner is data with `d_we = 1`.
  - The counter decrements each cycle. When the counter is 0:
    - a load or fetch captures `data_in_ram` into the owner's `*_rdata`;
    - the FSM moves to RESP.
- RESP:
  - The owner's `*_rvalid` is 1 for this single cycle.
  - Arbitration for the next access happens in this same cycle, exactly as in IDLE, so back-to-back accesses have no idle cycle.
  - If nothing is pending, the FSM moves to IDLE.
- Store acknowledge: `d_rvalid` pulses and `d_rdata` keeps its previous value.
- A requester holds its req, addr and wdata stable until it sees its gnt. After gnt it may change or drop them. `*_gnt` is never asserted in BUSY.
- `ram_adress` and `data_out_ram` keep their last values between accesses.
- `*_rdata` keeps its value until the next read completes for that requester.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, round-robin pointer = "data last served".
- Read: gnt in cycle T, `ram_adress` valid T+1 .. T+RAM_LAT, rvalid in cycle T+RAM_LAT+1.
- Throughput: one access per RAM_LAT+1 cycles.
- Store: `ram_enable_write` in cycle T+1, `d_rvalid` in cycle T+RAM_LAT+1.
- Both requests present in IDLE or RESP: exactly one gnt is asserted, according to the configured priority.
- `rst` during BUSY or RESP:
  - the access is aborted;
  - no rvalid is produced;
  - `ram_enable_write` is 0 from the next cycle;
  - the requester must re-request.
- Address and data are passed through unmodified. No alignment checks.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant goes to the requester not served last.
  - The pointer updates on every grant.
  - After reset, fetch wins the first tie.
- Undefined: fixed priority, data always beats fetch. The pointer logic is absent.

## Test plan
- Fetch only, RAM_LAT=1, `if_addr`=0x10, RAM returns 0xDEADBEEF:
  - `if_gnt` at T;
  - `if_rvalid` with `if_rdata`=0xDEADBEEF at T+2.
- Store `d_addr`=0x40, `d_wdata`=0x12345678:
  - `ram_enable_write`=1 for one cycle with `ram_adress`=0x40 and `data_out_ram`=0x12345678;
  - `d_rvalid` pulses;
  - `d_rdata` is unchanged.
- Both requesting continuously for 4 accesses, RAM_LAT=1:
  - with the macro, grants alternate F, D, F, D, each 2 cycles apart;
  - without it, grants are D, D, D, D and fetch is never granted.
- RAM_LAT=3, back-to-back loads:
  - gnts 4 cycles apart;
  - each rvalid lands exactly 4 cycles after its gnt;
  - no gnt is asserted during BUSY.
- `rst` asserted in the 2nd BUSY cycle of a load with RAM_LAT=3:
  - no `d_rvalid`;
  - all outputs 0 next cycle;
  - a new `if_req` is granted in the first cycle after `rst` drops.
